// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH independent programmable dividers producing 50 % square waves or
// one-cycle pulses, with shadowed divisor/mode updates applied at terminal count.
module clk_div_bank #(
    parameter int unsigned  NUM_CH      = 4,
    parameter int unsigned  CNT_W       = 20,
    parameter int unsigned  DEFAULT_DIV = 5000,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_restart,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending
);

    localparam logic [CNT_W-1:0] DefDiv =
        (DEFAULT_DIV == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);

    // A divisor of zero behaves exactly like one, so normalise it on the way in.
    logic [CNT_W-1:0] wr_div;
    assign wr_div = (cfg_div == '0) ? CNT_W'(1) : cfg_div;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] sdiv_q, sdiv_d;
        logic             mode_q, mode_d;
        logic             smode_q, smode_d;
        logic             pend_q, pend_d;
        logic             out_q, out_d;
        logic             tick_q, tick_d;
        logic             run_q;
        logic             wr, tc, flush, direct;

        assign wr = cfg_we && (cfg_ch == CH_W'(i));
        assign tc = (cnt_q == div_q - CNT_W'(1));

        always_comb begin
            cnt_d   = cnt_q;
            out_d   = out_q;
            tick_d  = 1'b0;
            div_d   = div_q;
            mode_d  = mode_q;
            sdiv_d  = sdiv_q;
            smode_d = smode_q;
            pend_d  = pend_q;
            flush   = 1'b0;
            direct  = 1'b0;

            if (sync_restart) begin
                cnt_d  = '0;
                out_d  = 1'b0;
                flush  = 1'b1;
                direct = 1'b1;
            end else if (!en[i] || !run_q) begin
                // Idle, or the first enabled edge: hold at zero so the first TC lands D edges on.
                cnt_d = '0;
                out_d = 1'b0;
                flush = 1'b1;
            end else if (tc) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                out_d  = mode_q ? 1'b1 : ~out_q;
                flush  = 1'b1;
                direct = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mode_q) begin
                    out_d = 1'b0;
                end
            end

            if (wr) begin
                sdiv_d  = wr_div;
                smode_d = cfg_mode;
                if (direct) begin
                    div_d  = wr_div;
                    mode_d = cfg_mode;
                    pend_d = 1'b0;
                end else begin
                    pend_d = 1'b1;
                end
            end else if (pend_q && flush) begin
                div_d  = sdiv_q;
                mode_d = smode_q;
                pend_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                div_q   <= DefDiv;
                mode_q  <= 1'b0;
                sdiv_q  <= DefDiv;
                smode_q <= 1'b0;
                pend_q  <= 1'b0;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
                run_q   <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                div_q   <= div_d;
                mode_q  <= mode_d;
                sdiv_q  <= sdiv_d;
                smode_q <= smode_d;
                pend_q  <= pend_d;
                out_q   <= out_d;
                tick_q  <= tick_d;
                run_q   <= en[i];
            end
        end

        assign clk_out[i]     = out_q;
        assign tick[i]        = tick_q;
        assign cfg_pending[i] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed stimulus for clk_div_bank, checked every cycle against an
// elapsed-edge model of each channel plus hand-computed literal expectations.
module tb_clk_div_bank;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int DDIV = 5;

    logic           clk          = 1'b0;
    logic           rst_n        = 1'b0;
    logic [NCH-1:0] en           = '0;
    logic           sync_restart = 1'b0;
    logic           cfg_we       = 1'b0;
    logic [1:0]     cfg_ch       = '0;
    logic [CW-1:0]  cfg_div      = '0;
    logic           cfg_mode     = 1'b0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] cfg_pending;

    clk_div_bank #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sync_restart (sync_restart),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_mode     (cfg_mode),
        .clk_out      (clk_out),
        .tick         (tick),
        .cfg_pending  (cfg_pending)
    );

    always #5 clk = ~clk;

    // Model: per channel, edges elapsed since the period origin; a TC is a full D of them.
    int m_d     [NCH];
    bit m_mode  [NCH];
    int m_sd    [NCH];
    bit m_smode [NCH];
    bit m_pend  [NCH];
    int m_ph    [NCH];
    bit m_lvl   [NCH];
    bit m_tick  [NCH];
    bit m_run   [NCH];
    bit m_valid = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_d[c] = DDIV; m_mode[c] = 1'b0; m_sd[c] = DDIV; m_smode[c] = 1'b0;
            m_pend[c] = 1'b0; m_ph[c] = 0; m_lvl[c] = 1'b0; m_tick[c] = 1'b0;
            m_run[c] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit wr;
            bit at_tc;
            int nd;
            wr    = cfg_we && (int'(cfg_ch) == c);
            nd    = (cfg_div == 0) ? 1 : int'(cfg_div);
            at_tc = 1'b0;
            m_tick[c] = 1'b0;
            if (sync_restart || !en[c] || !m_run[c]) begin
                m_ph[c]  = 0;
                m_lvl[c] = 1'b0;
                at_tc    = sync_restart;
                if (wr && !at_tc) begin
                    m_sd[c] = nd; m_smode[c] = cfg_mode; m_pend[c] = 1'b1;
                end else if (!wr && m_pend[c]) begin
                    m_d[c] = m_sd[c]; m_mode[c] = m_smode[c]; m_pend[c] = 1'b0;
                end
            end else begin
                m_ph[c] = m_ph[c] + 1;
                if (m_ph[c] == m_d[c]) begin
                    at_tc     = 1'b1;
                    m_ph[c]   = 0;
                    m_tick[c] = 1'b1;
                    m_lvl[c]  = m_mode[c] ? 1'b1 : !m_lvl[c];
                    if (!wr && m_pend[c]) begin
                        m_d[c] = m_sd[c]; m_mode[c] = m_smode[c]; m_pend[c] = 1'b0;
                    end
                end else begin
                    if (m_mode[c]) m_lvl[c] = 1'b0;
                    if (wr) begin
                        m_sd[c] = nd; m_smode[c] = cfg_mode; m_pend[c] = 1'b1;
                    end
                end
            end
            if (wr && at_tc) begin
                m_d[c] = nd; m_mode[c] = cfg_mode; m_sd[c] = nd; m_smode[c] = cfg_mode;
                m_pend[c] = 1'b0;
            end
            m_run[c] = en[c];
        end
    endtask

    function automatic logic [NCH-1:0] exp_out();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_lvl[c];
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_tick();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_tick[c];
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_pend();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_pend[c];
        return v;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_clk_out", 32'(clk_out), 32'(exp_out()));
            chk("model_tick", 32'(tick), 32'(exp_tick()));
            chk("model_cfg_pending", 32'(cfg_pending), 32'(exp_pend()));
        end
    end

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic cfg_write(input int ch, input int div, input bit mode);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_div  = CW'(div);
        cfg_mode = mode;
    endtask

    task automatic wait_tc0(input string name);
        int n;
        n = 0;
        while ((m_ph[0] + 1 != m_d[0]) && n < 20) begin
            step();
            n++;
        end
        chk(name, 32'(n < 20), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_clk_out", 32'(clk_out), 32'(0));
        chk("reset_tick", 32'(tick), 32'(0));
        chk("reset_pending", 32'(cfg_pending), 32'(0));
        rst_n   = 1'b1;
        m_valid = 1'b1;

        // Default divisor on ch0 only
        en = 4'b0001;
        step();
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 4) chk("def_tick_e4", 32'(tick[0]), 32'(0));
            if (k == 5) begin
                chk("def_tick_e5", 32'(tick[0]), 32'(1));
                chk("def_out_e5", 32'(clk_out[0]), 32'(1));
            end
            if (k == 10) begin
                chk("def_out_e10", 32'(clk_out[0]), 32'(0));
                chk("def_tick_e10", 32'(tick[0]), 32'(1));
            end
            if (k == 20) chk("def_idle_chs", 32'(clk_out[3:1]), 32'(0));
        end

        // Pulse mode on ch1, configured while disabled
        cfg_write(1, 3, 1'b1);
        step();
        cfg_we = 1'b0;
        chk("pulse_pend_set", 32'(cfg_pending[1]), 32'(1));
        step();
        chk("pulse_pend_clr", 32'(cfg_pending[1]), 32'(0));
        en = 4'b0011;
        step();
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 2) chk("pulse_tick_e2", 32'(tick[1]), 32'(0));
            if (k == 3) begin
                chk("pulse_tick_e3", 32'(tick[1]), 32'(1));
                chk("pulse_out_e3", 32'(clk_out[1]), 32'(1));
            end
            if (k == 4) chk("pulse_out_e4", 32'(clk_out[1]), 32'(0));
            if (k == 6) chk("pulse_tick_e6", 32'(tick[1]), 32'(1));
        end

        // Glitch-free divisor change on ch0 mid-period
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        step();
        step();
        cfg_write(0, 2, 1'b0);
        step();
        cfg_we = 1'b0;
        chk("gf_pend_e3", 32'(cfg_pending[0]), 32'(1));
        step();
        chk("gf_pend_e4", 32'(cfg_pending[0]), 32'(1));
        step();
        chk("gf_tick_e5", 32'(tick[0]), 32'(1));
        chk("gf_out_e5", 32'(clk_out[0]), 32'(1));
        chk("gf_pend_e5", 32'(cfg_pending[0]), 32'(0));
        step();
        chk("gf_tick_e6", 32'(tick[0]), 32'(0));
        step();
        chk("gf_out_e7", 32'(clk_out[0]), 32'(0));
        chk("gf_tick_e7", 32'(tick[0]), 32'(1));
        step();
        step();
        chk("gf_out_e9", 32'(clk_out[0]), 32'(1));

        // Boundary divisors: ch2 D=0 toggle, ch3 D=1 pulse
        cfg_write(2, 0, 1'b0);
        step();
        cfg_write(3, 1, 1'b1);
        step();
        cfg_we = 1'b0;
        step();
        chk("bd_pend_applied", 32'(cfg_pending), 32'(0));
        en = 4'b1111;
        step();
        step();
        chk("bd_d0_out_e1", 32'(clk_out[2]), 32'(1));
        chk("bd_d1p_out_e1", 32'(clk_out[3]), 32'(1));
        chk("bd_d1p_tick_e1", 32'(tick[3]), 32'(1));
        step();
        chk("bd_d0_out_e2", 32'(clk_out[2]), 32'(0));
        chk("bd_d1p_out_e2", 32'(clk_out[3]), 32'(1));
        // D=1 toggle: every edge is a TC, so the write bypasses the shadow
        cfg_write(2, 1, 1'b0);
        step();
        cfg_we = 1'b0;
        chk("bd_d1t_pend", 32'(cfg_pending[2]), 32'(0));
        chk("bd_d1t_out_e3", 32'(clk_out[2]), 32'(1));

        // Write on ch0's TC edge takes effect immediately
        wait_tc0("tcw_wait");
        cfg_write(0, 3, 1'b0);
        step();
        cfg_we = 1'b0;
        chk("tcw_tick", 32'(tick[0]), 32'(1));
        chk("tcw_pend", 32'(cfg_pending[0]), 32'(0));
        step();
        step();
        chk("tcw_tick_e2", 32'(tick[0]), 32'(0));
        step();
        chk("tcw_tick_e3", 32'(tick[0]), 32'(1));

        // sync_restart on a TC edge wins over the TC
        wait_tc0("sr_wait");
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        chk("sr_out", 32'(clk_out), 32'(0));
        chk("sr_tick", 32'(tick), 32'(0));
        step();
        chk("sr_tick_e1", 32'(tick), 32'(4'b1100));
        chk("sr_out_e1", 32'(clk_out), 32'(4'b1100));
        step();
        chk("sr_tick_e2", 32'(tick), 32'(4'b1100));
        step();
        chk("sr_tick_e3", 32'(tick), 32'(4'b1111));
        chk("sr_out_e3", 32'(clk_out), 32'(4'b1111));

        // Async reset mid-count clears outputs and a pending write
        cfg_write(1, 7, 1'b0);
        step();
        cfg_we = 1'b0;
        chk("ar_pend_before", 32'(cfg_pending[1]), 32'(1));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_out", 32'(clk_out), 32'(0));
        chk("ar_tick", 32'(tick), 32'(0));
        chk("ar_pend", 32'(cfg_pending), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 4) chk("ar_tick_e4", 32'(tick), 32'(0));
            if (k == 5) begin
                chk("ar_tick_e5", 32'(tick), 32'(4'b1111));
                chk("ar_out_e5", 32'(clk_out), 32'(4'b1111));
            end
        end

        m_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel programmable clock/tick generator: the parametrised successor of the single fixed divider. `NUM_CH` independent channels derive slow enables or square waves from `clk`, e.g. game-timer ticks, LED scan, debounce sampling. Each channel has a runtime divisor, a per-channel mode (50 % square wave or one-cycle pulse) and an enable. Divisor changes apply glitch-free at the next terminal count.

## Interface

Parameters:
- `NUM_CH`, 4: number of channels (≥1).
- `CNT_W`, 20: divisor/counter width.
- `DEFAULT_DIV`, 5000: active divisor of every channel after reset.

Ports:
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in `NUM_CH`: per-channel run enable.
- `sync_restart` in 1: one-cycle pulse that re-phases all channels.
- `cfg_we` in 1: configuration write strobe.
- `cfg_ch` in `max(1,$clog2(NUM_CH))`: target channel. Out-of-range values are ignored.
- `cfg_div` in `CNT_W`: new divisor D. D = 0 is treated as 1.
- `cfg_mode` in 1: 0 = toggle (square, period 2D); 1 = pulse (1-cycle high, period D).
- `clk_out` out `NUM_CH`: registered divided output per channel.
- `tick` out `NUM_CH`: registered one-cycle pulse at each terminal count, in both modes.
- `cfg_pending` out `NUM_CH`: high while a written configuration is waiting to be applied.

## Operation

- Each channel holds: counter `cnt`, active divisor/mode, shadow divisor/mode, pending flag.
- Reset (`rst_n` low, async):
  - cnt = 0, `clk_out` = 0, `tick` = 0, `cfg_pending` = 0.
  - Active divisor = `DEFAULT_DIV`, active mode = toggle.
  - Shadow registers = active values.
- Counting (en=1): if cnt == D−1 (terminal count, TC), then cnt ← 0, `tick` ← 1; otherwise cnt ← cnt+1, `tick` ← 0.
- Output at TC:
  - Toggle mode: `clk_out` ← ~`clk_out`.
  - Pulse mode: `clk_out` ← 1; it is 0 in every non-TC cycle.
- D = 1:
  - Toggle mode gives `clk_out` period 2.
  - Pulse mode holds `clk_out` and `tick` constantly high.
- Config write (`cfg_we`, valid `cfg_ch`): shadow ← {`cfg_div`, `cfg_mode`}, pending ← 1. A later write before application overwrites the shadow; the last write wins.
- Application: at a channel's TC with pending=1, active ← shadow, pending ← 0, and counting continues from cnt=0 with the new D.
  - The TC itself uses the old mode for that edge's `clk_out` update.
  - Switching into toggle mode keeps the current `clk_out` level.
- Write in the same cycle as that channel's TC: the written value bypasses the shadow and becomes active at that TC. pending stays 0.
- Disabled (en=0):
  - cnt ← 0, `clk_out` ← 0, `tick` ← 0.
  - Any pending config is applied on the next edge.
- Enable rising: counting starts from cnt=0.
- `sync_restart`: on every channel, cnt ← 0, `clk_out` ← 0, `tick` ← 0, and pending configs are applied.
  - Takes priority over TC and enable.
  - A `cfg_we` in the same cycle is applied directly.
- Channels are fully independent apart from `sync_restart` and the shared config port.

## Timing

- All outputs are registered. There is no combinational path from inputs to outputs.
- Let the edge where `en` is first sampled high be edge 0, with cnt = 0 before it.
  - TC edges occur at edges D, 2D, 3D, …
  - `tick`/`clk_out` are updated after those edges.
- Toggle mode: first rising `clk_out` after edge D, first falling after edge 2D. Duty cycle is exactly 50 %.
- `cfg_pending` rises the cycle after `cfg_we` and falls after the applying edge.
- Latency of a config change is at most D_old cycles plus 1 while enabled, and 1 cycle while disabled.
- `sync_restart` takes effect at the next edge. The first TC after it is D edges later.
- Reset deassertion mid-operation restarts from the reset state. No partial state survives.

## Test plan

- **Reset defaults:** reset, then `en`=0001 with NUM_CH=4 and DEFAULT_DIV=5 → ch0 `clk_out` toggles every 5 cycles (period 10); `tick` pulses every 5 cycles; ch1–3 stay 0.
- **Pulse mode:** write ch1 D=3, mode=1 while disabled; `cfg_pending[1]` is high 1 cycle; enable → `clk_out[1]` and `tick[1]` high 1 of every 3 cycles, first after edge 3.
- **Glitch-free change:** ch0 running with D=5; write D=2 mid-period → old period completes; after that TC the period is 4 (toggle); `cfg_pending[0]` clears at that TC.
- **Boundary divisors:** D=0 and D=1 in toggle mode → period-2 square wave. D=1 in pulse mode → constant high.
- **Same-cycle events:** `cfg_we` on a TC cycle → new D is used immediately with no pending. `sync_restart` together with TC → all cnt=0 and outputs 0, then the first TC is D edges later on every channel.
- **Async reset mid-count:** pulse `rst_n` low → outputs go to 0 immediately and the active divisor returns to DEFAULT_DIV.
